// File: rtl/stream_buffer_reader_pkg.sv
// Shared types and constants for the stream buffer reader: request/metadata
// layouts, FSM encoding and the beat-count helper.
package stream_buffer_reader_pkg;
  localparam int AXI_DATA_BITS       = 512;
  localparam int DATA_BYTES          = AXI_DATA_BITS / 8;
  localparam int VADDR_BITS          = 48;
  localparam int LEN_BITS            = 28;
  localparam int SIZE_BITS           = 32;
  localparam int TRANSFER_SIZE_BYTES = 4096;
  localparam int BEAT_BITS           = $clog2(TRANSFER_SIZE_BYTES / DATA_BYTES) + 1;

  localparam logic [4:0] OPC_READ  = 5'h01;
  localparam logic [1:0] STRM_CARD = 2'd1;

  typedef logic [VADDR_BITS-1:0] vaddress_t;

  typedef struct packed {
    logic [BEAT_BITS-1:0] beats;
    logic                 tlast;
  } read_meta_t;

  typedef struct packed {
    logic [4:0]          opcode;
    logic [1:0]          strm;
    logic [3:0]          dest;
    vaddress_t           vaddr;
    logic [LEN_BITS-1:0] len;
    logic                last;
  } req_t;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_ISSUE = 1'b1
  } state_t;

  // Number of data beats needed to carry len bytes (rounded up).
  function automatic logic [BEAT_BITS-1:0] len_to_beats(input logic [LEN_BITS-1:0] len);
    logic [LEN_BITS-1:0] b;
    b = (len + LEN_BITS'(DATA_BYTES - 1)) / LEN_BITS'(DATA_BYTES);
    return b[BEAT_BITS-1:0];
  endfunction
endpackage

// File: rtl/stream_buffer_reader_fifo.sv
// Synchronous FIFO of per-request metadata; a pop and push in the same cycle
// are both honoured even when full.
module read_meta_fifo
  import stream_buffer_reader_pkg::*;
#(
  parameter int DEPTH = 8
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       push,
  input  read_meta_t wdata,
  input  logic       pop,
  output read_meta_t rdata,
  output logic       full,
  output logic       empty
);
  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CNT_W = $clog2(DEPTH + 1);

  read_meta_t       mem_q [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             push_ok, pop_ok;

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(DEPTH - 1)) ? '0 : p + PTR_W'(1);
  endfunction

  assign full    = (count_q == CNT_W'(DEPTH));
  assign empty   = (count_q == '0);
  assign rdata   = mem_q[rd_ptr_q];
  assign pop_ok  = pop && !empty;
  // The pop frees a slot first, so a push into a full FIFO is not lost.
  assign push_ok = push && (!full || pop_ok);

  always_comb begin
    wr_ptr_d = push_ok ? ptr_inc(wr_ptr_q) : wr_ptr_q;
    rd_ptr_d = pop_ok ? ptr_inc(rd_ptr_q) : rd_ptr_q;
    count_d  = count_q + CNT_W'(push_ok) - CNT_W'(pop_ok);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  always_ff @(posedge clk) begin
    if (push_ok) mem_q[wr_ptr_q] <= wdata;
  end
endmodule

// File: rtl/stream_buffer_reader.sv
// Consumer end of the stream buffer link: splits chunk descriptors into card
// read requests, bounds outstanding reads and forwards returned data.
module stream_buffer_reader
  import stream_buffer_reader_pkg::*;
#(
  parameter int AXI_STRM_ID     = 0,
  parameter int TRANSFER_SIZE   = TRANSFER_SIZE_BYTES,
  parameter int MAX_OUTSTANDING = 4,
  parameter int META_DEPTH      = 8
) (
  input  logic                     clk,
  input  logic                     rst,
  input  vaddress_t                link_vaddr,
  input  logic [SIZE_BITS-1:0]     link_size,
  input  logic                     link_last,
  input  logic                     link_valid,
  output logic                     link_ready,
  output req_t                     sq_rd_data,
  output logic                     sq_rd_valid,
  input  logic                     sq_rd_ready,
  input  logic                     cq_rd_valid,
  output logic                     cq_rd_ready,
  input  logic [AXI_DATA_BITS-1:0] in_tdata,
  input  logic [DATA_BYTES-1:0]    in_tkeep,
  input  logic                     in_tlast,
  input  logic                     in_tvalid,
  output logic                     in_tready,
  output logic [AXI_DATA_BITS-1:0] out_tdata,
  output logic [DATA_BYTES-1:0]    out_tkeep,
  output logic                     out_tlast,
  output logic                     out_tvalid,
  input  logic                     out_tready,
  output logic                     zero_size_err,
  output state_t                   state_dbg
);
  localparam int OUT_W = $clog2(MAX_OUTSTANDING + 1);

  state_t               state_q, state_d;
  vaddress_t            cur_vaddr_q, cur_vaddr_d;
  logic [SIZE_BITS-1:0] remaining_q, remaining_d;
  logic                 chunk_last_q, chunk_last_d;
  logic                 zero_size_err_q, zero_size_err_d;
  logic [OUT_W-1:0]     outstanding_q, outstanding_d;
  logic [BEAT_BITS-1:0] beat_cnt_q, beat_cnt_d;

  logic [LEN_BITS-1:0]  req_len;
  logic                 final_req, issue;
  logic                 meta_push, meta_pop, meta_full, meta_empty;
  read_meta_t           meta_wdata, meta_head;
  logic                 beat_fire, beat_last;
  logic                 unused_in_tlast;

  // Every port pair moves a transfer on a cycle where valid && ready; a raised
  // valid and its payload stay put until then.
  assign final_req = (remaining_q <= SIZE_BITS'(TRANSFER_SIZE));
  assign req_len   = final_req ? remaining_q[LEN_BITS-1:0] : LEN_BITS'(TRANSFER_SIZE);
  assign issue     = sq_rd_valid && sq_rd_ready;

  always_comb begin
    state_d         = state_q;
    cur_vaddr_d     = cur_vaddr_q;
    remaining_d     = remaining_q;
    chunk_last_d    = chunk_last_q;
    zero_size_err_d = zero_size_err_q;
    link_ready      = 1'b0;
    sq_rd_valid     = 1'b0;
    meta_push       = 1'b0;
    meta_wdata      = '0;
    case (state_q)
      ST_IDLE: begin
        link_ready = !rst;
        if (link_valid && link_ready) begin
          cur_vaddr_d  = link_vaddr;
          remaining_d  = link_size;
          chunk_last_d = link_last;
          if (link_size == '0) zero_size_err_d = 1'b1;
          else state_d = ST_ISSUE;
        end
      end
      ST_ISSUE: begin
        // Outstanding only falls and the FIFO only drains while a request waits,
        // so this throttle never withdraws an asserted valid.
        sq_rd_valid = (outstanding_q < OUT_W'(MAX_OUTSTANDING)) && !meta_full;
        if (issue) begin
          cur_vaddr_d      = cur_vaddr_q + vaddress_t'(req_len);
          remaining_d      = remaining_q - SIZE_BITS'(req_len);
          meta_push        = 1'b1;
          meta_wdata.beats = len_to_beats(req_len);
          meta_wdata.tlast = chunk_last_q && final_req;
          if (final_req) state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    sq_rd_data        = '0;
    sq_rd_data.opcode = OPC_READ;
    sq_rd_data.strm   = STRM_CARD;
    sq_rd_data.dest   = 4'(AXI_STRM_ID);
    sq_rd_data.vaddr  = cur_vaddr_q;
    sq_rd_data.len    = req_len;
    sq_rd_data.last   = 1'b1;
  end

  // Completions saturate at zero; issue plus completion cancels out.
  always_comb begin
    outstanding_d = outstanding_q;
    if (issue && !cq_rd_valid) outstanding_d = outstanding_q + OUT_W'(1);
    else if (!issue && cq_rd_valid && (outstanding_q != '0)) outstanding_d = outstanding_q - OUT_W'(1);
  end

  assign cq_rd_ready     = 1'b1;
  assign out_tvalid      = in_tvalid && !meta_empty;
  assign in_tready       = out_tready && !meta_empty;
  assign out_tdata       = in_tdata;
  assign out_tkeep       = in_tkeep;
  assign beat_fire       = out_tvalid && out_tready;
  assign beat_last       = (beat_cnt_q == meta_head.beats - BEAT_BITS'(1));
  assign out_tlast       = beat_last && meta_head.tlast;
  assign meta_pop        = beat_fire && beat_last;
  assign unused_in_tlast = in_tlast;
  assign zero_size_err   = zero_size_err_q;
  assign state_dbg       = state_q;

  always_comb begin
    beat_cnt_d = beat_cnt_q;
    if (beat_fire) beat_cnt_d = beat_last ? '0 : beat_cnt_q + BEAT_BITS'(1);
  end

  read_meta_fifo #(.DEPTH(META_DEPTH)) u_meta_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (meta_push),
    .wdata (meta_wdata),
    .pop   (meta_pop),
    .rdata (meta_head),
    .full  (meta_full),
    .empty (meta_empty)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q         <= ST_IDLE;
      cur_vaddr_q     <= '0;
      remaining_q     <= '0;
      chunk_last_q    <= 1'b0;
      zero_size_err_q <= 1'b0;
      outstanding_q   <= '0;
      beat_cnt_q      <= '0;
    end else begin
      state_q         <= state_d;
      cur_vaddr_q     <= cur_vaddr_d;
      remaining_q     <= remaining_d;
      chunk_last_q    <= chunk_last_d;
      zero_size_err_q <= zero_size_err_d;
      outstanding_q   <= outstanding_d;
      beat_cnt_q      <= beat_cnt_d;
    end
  end
endmodule

// File: tb/tb_stream_buffer_reader.sv
// Bench for stream_buffer_reader: descriptor driver, card memory responder and
// a descriptor-level reference model feeding request and beat scoreboards.
module tb_stream_buffer_reader;
  import stream_buffer_reader_pkg::*;

  localparam int MAX_OUT    = 4;
  localparam int META_DEPTH = 8;
  localparam int TS         = 4096;
  localparam int BW         = 129;

  logic                     clk = 1'b0;
  logic                     rst = 1'b1;
  vaddress_t                link_vaddr;
  logic [SIZE_BITS-1:0]     link_size;
  logic                     link_last, link_valid, link_ready;
  req_t                     sq_rd_data;
  logic                     sq_rd_valid, sq_rd_ready;
  logic                     cq_rd_valid, cq_rd_ready;
  logic [AXI_DATA_BITS-1:0] in_tdata, out_tdata;
  logic [DATA_BYTES-1:0]    in_tkeep, out_tkeep;
  logic                     in_tlast, in_tvalid, in_tready;
  logic                     out_tlast, out_tvalid, out_tready;
  logic                     zero_size_err;
  state_t                   state_dbg;

  stream_buffer_reader #(
    .AXI_STRM_ID(0), .TRANSFER_SIZE(TS), .MAX_OUTSTANDING(MAX_OUT), .META_DEPTH(META_DEPTH)
  ) dut (
    .clk(clk), .rst(rst),
    .link_vaddr(link_vaddr), .link_size(link_size), .link_last(link_last),
    .link_valid(link_valid), .link_ready(link_ready),
    .sq_rd_data(sq_rd_data), .sq_rd_valid(sq_rd_valid), .sq_rd_ready(sq_rd_ready),
    .cq_rd_valid(cq_rd_valid), .cq_rd_ready(cq_rd_ready),
    .in_tdata(in_tdata), .in_tkeep(in_tkeep), .in_tlast(in_tlast),
    .in_tvalid(in_tvalid), .in_tready(in_tready),
    .out_tdata(out_tdata), .out_tkeep(out_tkeep), .out_tlast(out_tlast),
    .out_tvalid(out_tvalid), .out_tready(out_tready),
    .zero_size_err(zero_size_err), .state_dbg(state_dbg)
  );

  // ---------------- clock ----------------
  always #5 clk = ~clk;

  // ---------------- model state / scoreboard ----------------
  typedef struct {
    vaddress_t   vaddr;
    int unsigned len;
    logic        tl;
  } exp_req_t;

  exp_req_t    exp_req_q[$];
  logic [BW-1:0] exp_q[$];
  logic [BW-1:0] data_q[$];
  int unsigned meta_q[$];
  int          model_out = 0;
  int          cpl_pending = 0;
  int          checks = 0;
  int          errors = 0;
  int          n_req = 0, n_beats = 0, n_tlast = 0;
  bit          cq_hold = 0, cq_kick = 0, in_took = 0;
  int          sq_rdy_pct = 100, out_rdy_pct = 70;

  task automatic check(input string tag, input logic [BW-1:0] got, input logic [BW-1:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // ---------------- input drivers (posedge + 1) ----------------
  initial begin
    logic [63:0] dd, kk;
    logic        tlb;
    link_valid = 0; link_vaddr = '0; link_size = '0; link_last = 0;
    sq_rd_ready = 0; cq_rd_valid = 0; out_tready = 0;
    in_tvalid = 0; in_tdata = '0; in_tkeep = '0; in_tlast = 0;
    forever begin
      @(posedge clk); #1;
      sq_rd_ready = ($urandom_range(99) < sq_rdy_pct);
      out_tready  = ($urandom_range(99) < out_rdy_pct);
      cq_rd_valid = 0;
      if (cq_kick) begin
        cq_rd_valid = 1; cq_kick = 0;
      end else if (!cq_hold && cpl_pending > 0 && $urandom_range(1) == 1) begin
        cq_rd_valid = 1; cpl_pending--;
      end
      if (in_took || !in_tvalid) begin
        in_took = 0;
        if (data_q.size() > 0 && $urandom_range(99) < 80) begin
          {tlb, kk, dd} = data_q[0];
          in_tvalid = 1; in_tdata = {8{dd}}; in_tkeep = kk; in_tlast = tlb;
        end else in_tvalid = 0;
      end
    end
  end

  // ---------------- monitor / card responder (negedge) ----------------
  initial begin
    logic        prev_pend, in_hs, out_hs;
    req_t        prev_req;
    exp_req_t    er;
    int          nb;
    logic [63:0] dd, kk;
    logic [BW-1:0] e;
    prev_pend = 0;
    forever begin
      @(negedge clk);
      if (rst) begin prev_pend = 0; continue; end
      if (prev_pend) begin
        check("sq_hold_valid", sq_rd_valid, 1);
        check("sq_hold_data", sq_rd_data, prev_req);
      end
      if (sq_rd_valid)
        check("sq_throttle", (model_out < MAX_OUT) && (meta_q.size() < META_DEPTH), 1);
      prev_pend = sq_rd_valid && !sq_rd_ready;
      prev_req  = sq_rd_data;
      if (sq_rd_valid && sq_rd_ready) begin
        n_req++;
        if (exp_req_q.size() == 0) check("sq_unexpected", 1, 0);
        else begin
          er = exp_req_q.pop_front();
          check("sq_vaddr", sq_rd_data.vaddr, er.vaddr);
          check("sq_len", sq_rd_data.len, er.len);
          check("sq_fields", {sq_rd_data.opcode, sq_rd_data.strm, sq_rd_data.dest, sq_rd_data.last},
                {OPC_READ, STRM_CARD, 4'd0, 1'b1});
          nb = int'((er.len + 63) / 64);
          meta_q.push_back(nb);
          for (int b = 0; b < nb; b++) begin
            dd = {$urandom, $urandom};
            kk = {$urandom, $urandom};
            data_q.push_back({1'($urandom_range(1)), kk, dd});
            exp_q.push_back({er.tl && (b == nb - 1), kk, dd});
          end
          cpl_pending++;
        end
      end
      if (sq_rd_valid && sq_rd_ready && !cq_rd_valid) model_out++;
      else if (!(sq_rd_valid && sq_rd_ready) && cq_rd_valid && model_out > 0) model_out--;
      in_hs  = in_tvalid && in_tready;
      out_hs = out_tvalid && out_tready;
      if (in_hs || out_hs) check("hs_match", in_hs, out_hs);
      if (in_hs) begin
        if (data_q.size() > 0) void'(data_q.pop_front());
        in_took = 1;
      end
      if (out_hs) begin
        n_beats++;
        if (out_tlast) n_tlast++;
        if (exp_q.size() == 0) check("out_unexpected", 1, 0);
        else begin
          e = exp_q.pop_front();
          check("out_beat", {out_tlast, out_tkeep, out_tdata[63:0]}, e);
        end
        if (meta_q.size() > 0) begin
          meta_q[0]--;
          if (meta_q[0] == 0) void'(meta_q.pop_front());
        end
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic send_desc(input vaddress_t va, input int unsigned size, input bit last);
    exp_req_t    er;
    vaddress_t   a;
    int unsigned rem, len;
    int          n;
    @(posedge clk); #1;
    link_valid = 1; link_vaddr = va; link_size = size; link_last = last;
    n = 0;
    do begin @(negedge clk); n++; end while (!link_ready && n < 5000);
    check("link_accept", link_ready, 1);
    if (link_ready) begin
      a = va; rem = size;
      while (rem > 0) begin
        len = (rem < TS) ? rem : TS;
        er.vaddr = a; er.len = len; er.tl = last && (rem == len);
        exp_req_q.push_back(er);
        a = a + vaddress_t'(len);
        rem = rem - len;
      end
    end
    @(posedge clk); #1 link_valid = 0;
  endtask

  task automatic drain(input string tag);
    int n;
    n = 0;
    while ((exp_req_q.size() != 0 || exp_q.size() != 0 || cpl_pending != 0 || model_out != 0) && n < 20000) begin
      @(negedge clk); n++;
    end
    check(tag, n < 20000, 1);
    @(negedge clk);
  endtask

  task automatic do_reset();
    @(posedge clk); #1 rst = 1;
    @(posedge clk);
    @(negedge clk);
    check("rst_link_ready", link_ready, 0);
    check("rst_sq_valid", sq_rd_valid, 0);
    check("rst_out_tvalid", out_tvalid, 0);
    exp_req_q.delete(); exp_q.delete(); data_q.delete(); meta_q.delete();
    model_out = 0; cpl_pending = 0; cq_kick = 0; in_took = 1;
    @(posedge clk); #1 rst = 0;
    @(negedge clk);
    check("post_rst_link_ready", link_ready, 1);
    check("post_rst_sq_valid", sq_rd_valid, 0);
    check("post_rst_cq_ready", cq_rd_ready, 1);
    check("post_rst_out_tvalid", out_tvalid, 0);
    check("post_rst_in_tready", in_tready, 0);
    check("post_rst_zero_err", zero_size_err, 0);
    check("post_rst_state", state_dbg, ST_IDLE);
  endtask

  // ---------------- main sequence ----------------
  initial begin
    int          b0, t0, r0, sel;
    vaddress_t   va;
    int unsigned size;
    do_reset();

    // single chunk with latency checks
    b0 = n_beats; t0 = n_tlast; r0 = n_req;
    send_desc(48'h1000, 256, 1);
    @(negedge clk); check("lat_first_valid", sq_rd_valid, 1);
    @(negedge clk); check("lat_ready_back", link_ready, 1);
    drain("single_drain");
    check("single_reqs", n_req - r0, 1);
    check("single_beats", n_beats - b0, 4);
    check("single_tlast", n_tlast - t0, 1);

    // split chunk
    b0 = n_beats; t0 = n_tlast; r0 = n_req;
    send_desc(48'h0, 10000, 1);
    drain("split_drain");
    check("split_reqs", n_req - r0, 3);
    check("split_beats", n_beats - b0, 157);
    check("split_tlast", n_tlast - t0, 1);

    // non-last chunk followed by last chunk
    b0 = n_beats; t0 = n_tlast;
    send_desc(48'h0, 128, 0);
    send_desc(48'h80, 128, 1);
    drain("nonlast_drain");
    check("nonlast_beats", n_beats - b0, 4);
    check("nonlast_tlast", n_tlast - t0, 1);

    // zero size
    check("zero_err_clear", zero_size_err, 0);
    r0 = n_req;
    send_desc(48'h5000, 0, 1);
    @(negedge clk);
    check("zero_err_set", zero_size_err, 1);
    check("zero_no_valid", sq_rd_valid, 0);
    check("zero_ready", link_ready, 1);
    b0 = n_beats;
    send_desc(48'h40, 64, 1);
    drain("zero_next_drain");
    check("zero_next_reqs", n_req - r0, 1);
    check("zero_next_beats", n_beats - b0, 1);

    // spurious completion while idle, then throttle
    cq_kick = 1;
    repeat (3) @(negedge clk);
    cq_hold = 1; r0 = n_req;
    send_desc(48'h10000, 8 * TS, 1);
    repeat (30) @(negedge clk);
    check("thr_count", n_req - r0, 4);
    check("thr_valid_low", sq_rd_valid, 0);
    cq_kick = 1;
    @(negedge clk); check("thr_still_low", sq_rd_valid, 0);
    @(negedge clk); check("thr_release", sq_rd_valid, 1);
    @(negedge clk); check("thr_count5", n_req - r0, 5);
    cq_hold = 0;
    drain("thr_drain");

    // randomized descriptors, back-to-back
    sq_rdy_pct = 60;
    for (int i = 0; i < 14; i++) begin
      sel  = $urandom_range(9);
      va   = vaddress_t'({$urandom, $urandom});
      size = $urandom_range(12000, 1);
      if (sel == 0) va = 48'hFFFF_FFFF_F800;
      if (sel == 1) size = TS * $urandom_range(3, 1);
      if (sel == 2) size = 0;
      if (sel == 3) size = $urandom_range(64, 1);
      out_rdy_pct = $urandom_range(100, 20);
      send_desc(va, size, 1'($urandom_range(1)));
      if (size == 0) begin @(negedge clk); check("zero_err_rand", zero_size_err, 1); end
    end
    drain("rand_drain");

    // reset in the middle of a chunk
    out_rdy_pct = 50; b0 = n_beats;
    send_desc(48'h2_0000, 20000, 1);
    repeat ($urandom_range(80, 30)) @(negedge clk);
    check("pre_reset_progress", n_beats > b0, 1);
    do_reset();
    b0 = n_beats; t0 = n_tlast;
    send_desc(48'h3000, 192, 1);
    drain("post_rst_drain");
    check("post_rst_beats", n_beats - b0, 3);
    check("post_rst_tlast", n_tlast - t0, 1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #900000;
    errors++;
    $display("FAIL watchdog: got timeout expected completion");
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
